// File: rtl/mul_div_unit_if.sv
// Request/response bundle for mul_div_unit: one valid/ready channel carrying
// op + operands in, one valid/ready channel carrying the result out.
// master = EX-stage side, slave = mul_div_unit.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Multiply: shift-add over magnitudes, product negated at the end when signs differ.
// Divide: restoring over magnitudes, quotient/remainder sign fixed up at the end.
// Divide-by-zero and signed overflow are resolved at accept and skip the iterations.
// Optional macro MUL_DIV_FAST_MUL_EN: multiplies are computed combinationally at
// accept and complete in one cycle; divides are unchanged.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi_q;      // product high half / partial remainder
    logic [XLEN-1:0] lo_q;      // multiplier bits (shifted out) / quotient bits (shifted in)
    logic [XLEN-1:0] mag_q;     // multiplicand magnitude / divisor magnitude
    logic            neg_q;     // negate product or quotient
    logic            neg_rem_q; // negate remainder
    logic [XLEN-1:0] result_q;
    logic            in_ready_q;
    logic            out_valid_q;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    // Accept-time decode: operand signedness, magnitudes and special cases
    logic            is_div, a_sgn, b_sgn, neg_a, neg_b, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;
    always_comb begin
        is_div      = bus.op[2];
        a_sgn       = is_div ? ~bus.op[0] : (bus.op != 3'b011);
        b_sgn       = is_div ? ~bus.op[0] : ~bus.op[1];
        neg_a       = a_sgn & bus.operand_a[XLEN-1];
        neg_b       = b_sgn & bus.operand_b[XLEN-1];
        mag_a       = cond_neg(bus.operand_a, neg_a);
        mag_b       = cond_neg(bus.operand_b, neg_b);
        special     = 1'b0;
        special_res = '0;
        if (is_div && (bus.operand_b == '0)) begin
            special     = 1'b1;
            special_res = bus.op[1] ? bus.operand_a : '1;
        end else if (is_div && !bus.op[0] &&
                     (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.operand_b == '1)) begin
            special     = 1'b1;
            special_res = bus.op[1] ? '0 : bus.operand_a;
        end
    end

`ifdef MUL_DIV_FAST_MUL_EN
    // Single-cycle signed/unsigned product of sign- or zero-extended operands
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_prod;
    logic [XLEN-1:0]          fast_res;
    always_comb begin
        fast_a    = {neg_a, bus.operand_a};
        fast_b    = {neg_b, bus.operand_b};
        fast_prod = (2*XLEN+2)'(fast_a) * (2*XLEN+2)'(fast_b);
        fast_res  = (bus.op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // One shift-add or restoring-subtract step, plus the sign fix-up for the final write
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic [XLEN-1:0]   iter_hi, iter_lo, final_res;
    logic [2*XLEN-1:0] mul_full;
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_trial = div_shift - {1'b0, mag_q};
        if (op_q[2]) begin
            if (!div_trial[XLEN]) begin
                iter_hi = div_trial[XLEN-1:0];
                iter_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                iter_hi = div_shift[XLEN-1:0];
                iter_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            iter_hi = mul_sum[XLEN:1];
            iter_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        mul_full = cond_neg2({hi_q, lo_q}, neg_q);
        if (op_q[2]) begin
            final_res = op_q[1] ? cond_neg(hi_q, neg_rem_q) : cond_neg(lo_q, neg_q);
        end else begin
            final_res = (op_q == 3'b000) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        end
    end

    // Control FSM and datapath state; reset beats flush, flush beats every handshake
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_q       <= bus.op;
                        neg_q      <= neg_a ^ neg_b;
                        neg_rem_q  <= neg_a;
                        hi_q       <= '0;
                        in_ready_q <= 1'b0;
                        if (special) begin
                            result_q    <= special_res;
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
`ifdef MUL_DIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            result_q    <= fast_res;
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
`endif
                        end else begin
                            state_q <= S_BUSY;
                            cnt_q   <= CNT_W'(XLEN);
                            lo_q    <= is_div ? mag_a : mag_b;
                            mag_q   <= is_div ? mag_b : mag_a;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                        hi_q  <= iter_hi;
                        lo_q  <= iter_lo;
                    end else begin
                        result_q    <= final_res;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (XLEN=32): vector table plus hand-written
// backpressure, flush and reset sequences.
module tb_mul_div_unit;
    logic clk;
    logic reset;
    logic flush;
    int   pass_cnt = 0;
    int   total_cnt = 0;

`ifdef MUL_DIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Issue one op (caller is just past a posedge, unit idle) and wait for out_valid
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        bit seen;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.operand_a = ~a;
        bus.operand_b = ~b;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus.out_valid;
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL %s timeout: out_valid not seen in %0d cycles", nm, n);
        end else begin
            check({nm, " latency"}, 64'(n), 64'(exp_lat));
            check({nm, " result"}, 64'(bus.result), 64'(exp_res));
        end
    endtask

    // Take the pending result and confirm the unit is ready again
    task automatic consume(input string nm);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({nm, " in_ready after take"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul 7*-3"};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh minneg^2"};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu ones"};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu -1*max"};
        vecs[4]  = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT, "mulh 7*-3"};
        vecs[5]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT, "div -7/2"};
        vecs[6]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT, "rem -7%2"};
        vecs[7]  = '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, DIV_LAT, "divu"};
        vecs[8]  = '{3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, DIV_LAT, "remu"};
        vecs[9]  = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, "div 7/-2"};
        vecs[10] = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPC_LAT, "divu by 0"};
        vecs[11] = '{3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPC_LAT, "rem by 0"};
        vecs[12] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, "div overflow"};
        vecs[13] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT, "rem overflow"};

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 3'b000;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);
            consume(vecs[i].name);
        end

        // Backpressure: result held, new request ignored while DONE
        run_op("bp divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);
        bus.op        = 3'b000;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd9;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp result stable", 64'(bus.result), 64'd14);
            check("bp in_ready low", 64'(bus.in_ready), 64'd0);
            check("bp out_valid held", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        consume("bp");
        @(posedge clk);
        #1;
        check("bp no ghost op", 64'(bus.out_valid), 64'd0);

        // Flush on the 10th BUSY cycle of a divide, with a competing request
        bus.op        = 3'b100;
        bus.operand_a = 32'hFFFF_FFF9;
        bus.operand_b = 32'd2;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush         = 1'b1;
        bus.op        = 3'b000;
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd5;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush in_ready", 64'(bus.in_ready), 64'd1);
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        begin
            bit rose;
            rose = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) rose = 1'b1;
            end
            check("flush out_valid never rises", 64'(rose), 64'd0);
        end
        run_op("mul 3*4 after flush", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);
        consume("mul 3*4");

        // Flush beats a same-cycle take of a pending result
        run_op("flush-done divu 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        check("flush-done out_valid", 64'(bus.out_valid), 64'd0);
        check("flush-done in_ready", 64'(bus.in_ready), 64'd1);
        check("flush-done result kept", 64'(bus.result), 64'hFFFF_FFFF);

        // Reset mid-BUSY returns everything to reset values
        bus.op        = 3'b101;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd3;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("busy in_ready low", 64'(bus.in_ready), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid reset in_ready", 64'(bus.in_ready), 64'd1);
        check("mid reset out_valid", 64'(bus.out_valid), 64'd0);
        check("mid reset result", 64'(bus.result), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("mid reset stays idle", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
